// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, flag bundle and opcode bound for the pipelined ALU.
`default_nettype none

package alu_pkg;

  typedef enum logic [4:0] {
    OP_BEQ  = 5'd0,
    OP_BNE  = 5'd1,
    OP_BLT  = 5'd2,
    OP_BGE  = 5'd3,
    OP_BLTU = 5'd4,
    OP_BGEU = 5'd5,
    OP_ADD  = 5'd6,
    OP_SUB  = 5'd7,
    OP_SLL  = 5'd8,
    OP_SLT  = 5'd9,
    OP_SLTU = 5'd10,
    OP_XOR  = 5'd11,
    OP_SRL  = 5'd12,
    OP_SRA  = 5'd13,
    OP_OR   = 5'd14,
    OP_AND  = 5'd15
  } alu_op_e;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic con_met;
    logic err;
  } alu_flags_t;

  localparam logic [4:0] ALU_OP_LAST = 5'd15;

endpackage

`default_nettype wire

// File: rtl/alu_exec.sv
// alu_exec: combinational ALU core mapping (opcode, A, B) to a result and its flags.
`default_nettype none

module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [SHW-1:0]  shamt;
  logic            lt_s;
  logic            lt_u;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_BEQ:  flags.con_met = (a == b);
      OP_BNE:  flags.con_met = (a != b);
      OP_BLT:  flags.con_met = lt_s;
      OP_BGE:  flags.con_met = !lt_s;
      OP_BLTU: flags.con_met = lt_u;
      OP_BGEU: flags.con_met = !lt_u;
      OP_ADD: begin
        result         = sum;
        // Same-signed operands whose sum flips sign.
        flags.overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        flags.zero     = (sum == '0);
      end
      OP_SUB: begin
        result         = diff;
        flags.overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
        flags.zero     = (diff == '0);
      end
      OP_SLL:  result = a << shamt;
      OP_SLT: begin
        result        = {{(XLEN-1){1'b0}}, lt_s};
        flags.con_met = lt_s;
      end
      OP_SLTU: begin
        result        = {{(XLEN-1){1'b0}}, lt_u};
        flags.con_met = lt_u;
      end
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = XLEN'($signed(a) >>> shamt);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: flags.err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready pipelined ALU with fixed latency, whole-pipe stall and tag pass-through.
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic                           soc_clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4:0]                     Instruction_to_ALU,
  input  logic [XLEN-1:0]                ALU_dat1,
  input  logic [XLEN-1:0]                ALU_dat2,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                ALU_out,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           ALU_overflow,
  output logic                           ALU_zero,
  output logic                           ALU_con_met,
  output logic                           ALU_err,
  output logic [$clog2(LATENCY+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(LATENCY+1);

  logic [LATENCY-1:0] vld;
  logic [XLEN-1:0]    res_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  alu_flags_t         flg_q [LATENCY];

  logic [XLEN-1:0]    exec_res;
  alu_flags_t         exec_flags;
  logic               stall;
  logic               accept;
  logic               retire;

  alu_exec #(.XLEN(XLEN)) u_exec (
    .op     (Instruction_to_ALU),
    .a      (ALU_dat1),
    .b      (ALU_dat2),
    .result (exec_res),
    .flags  (exec_flags)
  );

  assign out_valid = vld[LATENCY-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall && !reset;
  // Reset is handled by the flops themselves, so the data path only needs the stall term.
  assign accept    = in_valid && !stall;
  assign retire    = out_valid && out_ready;

  assign ALU_out      = res_q[LATENCY-1];
  assign out_tag      = tag_q[LATENCY-1];
  assign ALU_overflow = flg_q[LATENCY-1].overflow;
  assign ALU_zero     = flg_q[LATENCY-1].zero;
  assign ALU_con_met  = flg_q[LATENCY-1].con_met;
  assign ALU_err      = flg_q[LATENCY-1].err;

  // Payload registers load only behind a valid bit, so bubbles leave stale data untouched.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld[i]   <= 1'b0;
        res_q[i] <= '0;
        tag_q[i] <= '0;
        flg_q[i] <= '0;
      end
      occupancy <= '0;
    end else begin
      if (!stall) begin
        vld[0] <= accept;
        if (accept) begin
          res_q[0] <= exec_res;
          tag_q[0] <= in_tag;
          flg_q[0] <= exec_flags;
        end
        for (int i = 1; i < LATENCY; i++) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            res_q[i] <= res_q[i-1];
            tag_q[i] <= tag_q[i-1];
            flg_q[i] <= flg_q[i-1];
          end
        end
      end
      if (accept && !retire) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (retire && !accept) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table vectors, directed corner sequences and randomized traffic against a queue-based model.
`default_nettype none

module tb_alu_pipe;

  localparam int XLEN = 32;
  localparam int LAT  = 3;
  localparam int TW   = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        z;
    logic        cm;
    logic        err;
  } exp_t;

  typedef struct {
    exp_t       e;
    logic [3:0] tag;
    int         rdy;
  } sb_t;

  typedef struct {
    string       nm;
    logic [4:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [4:0]    op = '0;
  logic [31:0]   a = '0, b = '0, res;
  logic [TW-1:0] tag = '0, out_tag;
  logic          ov, z, cm, err;
  logic [1:0]    occ;

  logic          s_in_valid = 1'b0, s_in_ready, s_out_valid;
  logic [4:0]    s_op = '0;
  logic [15:0]   s_a = '0, s_b = '0, s_res;
  logic [TW-1:0] s_out_tag;
  logic          s_ov, s_z, s_cm, s_err;
  logic [0:0]    s_occ;

  alu_pipe #(.XLEN(XLEN), .LATENCY(LAT), .TAG_W(TW)) dut (
    .soc_clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instruction_to_ALU(op), .ALU_dat1(a), .ALU_dat2(b), .in_tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_out(res), .out_tag(out_tag),
    .ALU_overflow(ov), .ALU_zero(z), .ALU_con_met(cm), .ALU_err(err), .occupancy(occ)
  );

  alu_pipe #(.XLEN(16), .LATENCY(1), .TAG_W(TW)) dut16 (
    .soc_clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .Instruction_to_ALU(s_op), .ALU_dat1(s_a), .ALU_dat2(s_b), .in_tag(4'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .ALU_out(s_res), .out_tag(s_out_tag),
    .ALU_overflow(s_ov), .ALU_zero(s_z), .ALU_con_met(s_cm), .ALU_err(s_err), .occupancy(s_occ)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: signed values handled as 64-bit integers.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, wide;
    int     k;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    k  = int'(y % 32);
    case (o)
      5'd0:  e.cm = (x == y);
      5'd1:  e.cm = (x != y);
      5'd2:  e.cm = (sx < sy);
      5'd3:  e.cm = (sx >= sy);
      5'd4:  e.cm = (x < y);
      5'd5:  e.cm = (x >= y);
      5'd6: begin
        wide  = sx + sy;
        e.res = x + y;
        e.ov  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        e.z   = (e.res == 0);
      end
      5'd7: begin
        wide  = sx - sy;
        e.res = x - y;
        e.ov  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        e.z   = (e.res == 0);
      end
      5'd8:  e.res = x << k;
      5'd9: begin
        e.res = (sx < sy) ? 32'd1 : 32'd0;
        e.cm  = e.res[0];
      end
      5'd10: begin
        e.res = (x < y) ? 32'd1 : 32'd0;
        e.cm  = e.res[0];
      end
      5'd11: e.res = x ^ y;
      5'd12: e.res = x >> k;
      5'd13: e.res = 32'(sx >>> k);
      5'd14: e.res = x | y;
      5'd15: e.res = x & y;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  int   cyc = 0;
  always @(posedge clk) cyc++;

  sb_t  q[$];
  int   ret_cyc[$];
  int   ret_tag[$];
  int   max_occ = 0;
  int   n_acc = 0;
  int   n_ret = 0;
  logic prev_stall = 1'b0;
  logic [39:0] prev_out = '0;

  // Scoreboard: each accepted op becomes visible LAT edges later, plus one edge per stall cycle.
  always @(negedge clk) begin : mon
    logic ev, eready, stl;
    if (reset) begin
      check("reset_state", {out_valid, occ, res, out_tag, ov, z, cm, err, in_ready}, 64'd0);
      q.delete();
      prev_stall = 1'b0;
      n_acc = 0;
      n_ret = 0;
    end else begin
      ev     = (q.size() > 0) && (q[0].rdy <= cyc);
      eready = !(ev && !out_ready);
      check("out_valid", out_valid, ev);
      check("occupancy", occ, q.size());
      check("in_ready", in_ready, eready);
      if (ev && out_valid) check("result", {res, ov, z, cm, err, out_tag}, {q[0].e, q[0].tag});
      if (prev_stall) check("stall_stable", {res, ov, z, cm, err, out_tag}, prev_out);
      if (int'(occ) > max_occ) max_occ = int'(occ);
      stl = ev && !out_ready;
      if (stl) foreach (q[i]) q[i].rdy++;
      if (ev && out_ready) void'(q.pop_front());
      if (out_valid && out_ready) begin
        n_ret++;
        ret_cyc.push_back(cyc);
        ret_tag.push_back(int'(out_tag));
      end
      if (in_valid && eready) begin
        q.push_back('{model(op, a, b), tag, cyc + LAT});
        n_acc++;
      end
      prev_stall = stl;
      prev_out   = {res, ov, z, cm, err, out_tag};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  vec_t tbl[16];
  int   c0;
  logic got;

  initial begin
    tbl[0]  = '{"add_ovf",  5'd6,  32'h7FFFFFFF, 32'h00000001, exp_t'({32'h80000000, 4'b1000})};
    tbl[1]  = '{"sub_zero", 5'd7,  32'h00000005, 32'h00000005, exp_t'({32'h00000000, 4'b0100})};
    tbl[2]  = '{"bad_op20", 5'd20, 32'h00001234, 32'h00000005, exp_t'({32'h00000000, 4'b0001})};
    tbl[3]  = '{"blt_neg",  5'd2,  32'hFFFFFFFD, 32'h00000000, exp_t'({32'h00000000, 4'b0010})};
    tbl[4]  = '{"sltu",     5'd10, 32'hFFFFFFFF, 32'h00000001, exp_t'({32'h00000000, 4'b0000})};
    tbl[5]  = '{"slt",      5'd9,  32'hFFFFFFFF, 32'h00000001, exp_t'({32'h00000001, 4'b0010})};
    tbl[6]  = '{"sra",      5'd13, 32'h80000000, 32'h00000024, exp_t'({32'hF8000000, 4'b0000})};
    tbl[7]  = '{"sll",      5'd8,  32'h00000001, 32'h0000001F, exp_t'({32'h80000000, 4'b0000})};
    tbl[8]  = '{"sub_ovf",  5'd7,  32'h80000000, 32'h00000001, exp_t'({32'h7FFFFFFF, 4'b1000})};
    tbl[9]  = '{"bgeu",     5'd5,  32'h00000001, 32'hFFFFFFFF, exp_t'({32'h00000000, 4'b0000})};
    tbl[10] = '{"xor",      5'd11, 32'h0000F0F0, 32'h0000FF00, exp_t'({32'h00000FF0, 4'b0000})};
    tbl[11] = '{"add_wrap", 5'd6,  32'hFFFFFFFF, 32'h00000001, exp_t'({32'h00000000, 4'b0100})};
    tbl[12] = '{"beq",      5'd0,  32'h00000003, 32'h00000003, exp_t'({32'h00000000, 4'b0010})};
    tbl[13] = '{"bad_op31", 5'd31, 32'h00000000, 32'h00000000, exp_t'({32'h00000000, 4'b0001})};
    tbl[14] = '{"srl",      5'd12, 32'h80000000, 32'h0000001F, exp_t'({32'h00000001, 4'b0000})};
    tbl[15] = '{"bne",      5'd1,  32'h00000003, 32'h00000003, exp_t'({32'h00000000, 4'b0000})};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Table vectors, one at a time, with latency measured from the accepting cycle.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = tbl[i].o; a = tbl[i].x; b = tbl[i].y; tag = TW'(i);
      @(negedge clk); c0 = cyc;
      @(posedge clk); #1 in_valid = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (out_valid) got = 1'b1;
      end
      check({tbl[i].nm, "_latency"}, cyc - c0, LAT);
      check(tbl[i].nm, {res, ov, z, cm, err}, tbl[i].e);
    end

    // 16-bit, single-stage instance.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_op = (i == 0) ? 5'd13 : 5'd10;
      s_a  = (i == 0) ? 16'hF000 : 16'hFFFF;
      s_b  = (i == 0) ? 16'h0014 : 16'h0001;
      @(negedge clk);
      check("x16_in_ready", s_in_ready, 1'b1);
      @(posedge clk); #1 s_in_valid = 1'b0;
      @(negedge clk);
      check("x16_valid", s_out_valid, 1'b1);
      check((i == 0) ? "x16_sra" : "x16_sltu", {s_res, s_ov, s_z, s_cm, s_err},
            (i == 0) ? {16'hFF00, 4'b0000} : {16'h0000, 4'b0000});
    end

    // Streaming: 8 back-to-back ops, tags 0..7.
    repeat (4) @(negedge clk);
    ret_cyc.delete(); ret_tag.delete(); max_occ = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = 5'($urandom_range(0, 15)); a = $urandom; b = $urandom; tag = TW'(t);
      if (t == 0) begin
        @(negedge clk); c0 = cyc;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("stream_count", ret_cyc.size(), 8);
    if (ret_cyc.size() == 8) begin
      check("stream_first_latency", ret_cyc[0] - c0, LAT);
      for (int k = 1; k < 8; k++) begin
        check("stream_back_to_back", ret_cyc[k] - ret_cyc[0], k);
        check("stream_tag_order", ret_tag[k], k);
      end
    end
    check("occ_peak", max_occ, LAT);

    // Backpressure with a full pipe; the held op enters on the retiring edge.
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = 5'd6; a = 32'(t); b = 32'd100; tag = TW'(8 + t);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; op = 5'd7; a = 32'd50; b = 32'd8; tag = 4'd11;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_head_tag", out_tag, 4'd8);
      if (s < 3) @(posedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_no_loss", n_ret, n_acc);

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op  = 5'($urandom_range(0, 19));
      a   = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
      tag = TW'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);
    check("random_drain", q.size(), 0);
    check("random_no_loss", n_ret, n_acc);

    // Reset with two ops in flight; a fresh op must return with normal latency.
    @(posedge clk); #1; in_valid = 1'b1; op = 5'd6; a = 32'd1; b = 32'd1; tag = 4'd5;
    @(posedge clk); #1; tag = 4'd6;
    @(posedge clk); #1; in_valid = 1'b0;
    check("pre_reset_occ", occ, 2'd2);
    reset = 1'b1;
    #1;
    check("async_reset", {out_valid, occ}, 3'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 5'd6; a = 32'd2; b = 32'd3; tag = 4'd12;
    @(negedge clk); c0 = cyc;
    @(posedge clk); #1 in_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("post_reset_latency", cyc - c0, LAT);
    check("post_reset_result", {res, out_tag}, {32'd5, 4'd12});
    repeat (4) @(negedge clk);
    check("post_reset_single", n_ret, 1);
    check("final_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the existing single-issue ALU. It accepts one operation per cycle over a valid/ready handshake and returns the result after a configurable fixed latency. Full backpressure is supported, and each operation carries a tag for out-of-order bookkeeping upstream. It sits between the decode/operand-fetch stage and writeback/branch-resolve, using the same 5-bit opcode encoding and flag semantics.

## Interface
- `XLEN`, 32: operand/result width; legal values 16, 32, 64.
- `LATENCY`, 3: pipeline depth in cycles from accept to `out_valid`; legal range 1..4.
- `TAG_W`, 4: width of the pass-through tag.
- `soc_clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept this cycle.
- `Instruction_to_ALU` in 5: opcode.
- `ALU_dat1` in XLEN: operand A (rs1).
- `ALU_dat2` in XLEN: operand B (rs2/imm).
- `in_tag` in TAG_W: caller tag.
- `out_valid` out 1: result presented.
- `out_ready` in 1: consumer accepts this cycle.
- `ALU_out` out XLEN: result.
- `out_tag` out TAG_W: tag of the presented result.
- `ALU_overflow`, `ALU_zero`, `ALU_con_met`, `ALU_err` out 1 each: flags belonging to the presented result.
- `occupancy` out $clog2(LATENCY+1): number of valid stages.

## Operation
- Opcodes:
  - 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU.
  - 6 ADD, 7 SUB, 8 SLL, 9 SLT, 10 SLTU, 11 XOR, 12 SRL, 13 SRA, 14 OR, 15 AND.
  - 16..31 are invalid.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use only the low $clog2(XLEN) bits of B.
  - SRA sign-fills from A[XLEN-1].
  - SLT/SLTU write 0 or 1, zero-extended to XLEN.
- Flags:
  - `ALU_overflow`: set only for ADD/SUB on signed overflow, i.e. operand signs combine such that the result sign is inconsistent.
  - `ALU_zero`: set only for ADD/SUB when the result is 0; clear for all other opcodes.
  - `ALU_con_met`: for opcodes 0–5, the branch condition; for SLT/SLTU, result bit 0; otherwise 0.
  - `ALU_err`: set for invalid opcodes; `ALU_out` is 0 and all other flags are 0.
- Branch opcodes return `ALU_out` = 0.
- Stage 1 computes result and flags; stages 2..LATENCY register them unchanged. Each stage holds a valid bit, tag, result and flags.
- Stall:
  - `stall = out_valid && !out_ready`.
  - While stalled, every stage holds its contents and no new op is accepted.
  - No bubble collapse: the pipe advances as a single unit.
- `in_ready = !stall && !reset`. There is a combinational path from `out_ready` to `in_ready`, which is accepted.
- Accept condition: `in_valid && in_ready` at a rising edge.
- A cycle with `!in_valid && !stall` inserts a bubble (valid = 0) into stage 1.
- Output ports are driven directly from the last stage registers. When `out_valid` = 0 their values are don't-care, but they must hold stable.

## Timing
- Reset asserted:
  - All valid bits, `out_valid`, `ALU_out`, `out_tag`, all flags and `occupancy` go to 0 immediately.
  - `in_ready` is 0.
  - Any in-flight operations are discarded without being presented.
- First edge after reset is released: accepting is allowed, and `in_ready` is 1 because `out_valid` = 0.
- Latency: an op accepted at edge N appears with `out_valid` = 1 after edge N+LATENCY, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one op per cycle with `out_ready` held at 1.
- While `out_valid && !out_ready`: `ALU_out`, `out_tag` and all flags are bit-stable until the edge where `out_ready` = 1.
- `out_ready` rising in the same cycle that `in_valid` is high: the head result retires and the new op enters stage 1 on the same edge.
- `occupancy` updates each edge as: +1 on accept, −1 on retire; simultaneous accept and retire leaves it unchanged. Its maximum is LATENCY.

## Structure
- `alu_pkg`:
  - opcode enum `alu_op_e` (values 0..15 as listed);
  - `alu_flags_t` struct {overflow, zero, con_met, err};
  - constant `ALU_OP_LAST` = 15.
- Sub-module `alu_exec`: purely combinational, parametrised by XLEN. It maps (op, A, B) to (result, `alu_flags_t`) and is instantiated once at stage 1.
- `alu_pipe` owns the handshake, the stage registers and `occupancy`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 (XLEN=32) -> `ALU_out` 0x80000000, overflow = 1, zero = 0. SUB 5 − 5 -> 0, zero = 1.
- Streaming, LATENCY=3, `out_ready` held at 1, 8 back-to-back ops with tags 0..7 -> first `out_valid` 3 cycles after the first accept, then 8 consecutive results in tag order, `occupancy` peaks at 3.
- Backpressure: drop `out_ready` for 4 cycles while the pipe is full -> `in_ready` = 0, outputs bit-stable, no op lost or duplicated; all results retire once `out_ready` = 1.
- Opcode 20 with A = 0x1234 -> err = 1, `ALU_out` 0, other flags 0. BLT 0xFFFFFFFD vs 0 -> con_met = 1, `ALU_out` 0.
- XLEN=16: SRA 0xF000 by B = 0x0014 (low 4 bits = 4) -> 0xFF00. SLTU 0xFFFF < 1 -> 0, con_met = 0.
- Assert `reset` mid-stream with 2 ops in flight -> `out_valid` and `occupancy` go to 0 asynchronously; the dropped tags never appear; the first op after reset returns with correct latency.
